// File: rtl/ssd1306_pkg.sv
// Shared constants and types for the SSD1306 framebuffer raster read scheduler.
package ssd1306_pkg;

    localparam int unsigned OLED_COLS = 128;
    localparam int unsigned OLED_ROWS = 64;
    localparam int unsigned COL_BITS  = 7;
    localparam int unsigned PAGE_BITS = 3;
    localparam int unsigned BIT_BITS  = 3;
    localparam int unsigned ROW_BITS  = PAGE_BITS + BIT_BITS;
    localparam int unsigned FB_ADDR_W = 1 + PAGE_BITS + COL_BITS;
    localparam int unsigned POS_W     = 13;

    localparam logic [7:0] SSD1306_SET_CONTRAST    = 8'h81;
    localparam logic [7:0] SSD1306_DISPLAY_RAM     = 8'hA4;
    localparam logic [7:0] SSD1306_NORMAL_DISPLAY  = 8'hA6;
    localparam logic [7:0] SSD1306_INVERT_DISPLAY  = 8'hA7;
    localparam logic [7:0] SSD1306_DISPLAY_OFF     = 8'hAE;
    localparam logic [7:0] SSD1306_DISPLAY_ON      = 8'hAF;
    localparam logic [7:0] SSD1306_SET_MEM_MODE    = 8'h20;
    localparam logic [7:0] SSD1306_SET_COL_ADDR    = 8'h21;
    localparam logic [7:0] SSD1306_SET_PAGE_ADDR   = 8'h22;

    typedef enum logic {
        SWAP_IDLE = 1'b0,
        SWAP_ACK  = 1'b1
    } swap_state_t;

    // Framebuffer byte address as seen on rd_addr.
    typedef struct packed {
        logic                 bank;
        logic [PAGE_BITS-1:0] page;
        logic [COL_BITS-1:0]  col;
    } fb_addr_t;

    // Stage-1 pixel context held while the framebuffer byte is fetched.
    typedef struct packed {
        logic                de;
        logic                win;
        logic [BIT_BITS-1:0] bit_sel;
    } pix_stage_t;

endpackage

// File: rtl/ssd1306_bank_swap.sv
// Frame-aligned read-bank swap handshake with the SPI write side.
// The bank toggles only on the frame_start edge, so a frame never mixes banks.
module ssd1306_bank_swap
    import ssd1306_pkg::*;
(
    input  logic raster_clk,
    input  logic rst,
    input  logic frame_start,
    input  logic swap_req,
    output logic swap_ack,
    output logic rd_bank
);

    swap_state_t state;
    swap_state_t state_nxt;
    logic        ack_nxt;
    logic        bank_nxt;

    always_ff @(posedge raster_clk or posedge rst) begin
        if (rst) begin
            state    <= SWAP_IDLE;
            swap_ack <= 1'b0;
            rd_bank  <= 1'b0;
        end else begin
            state    <= state_nxt;
            swap_ack <= ack_nxt;
            rd_bank  <= bank_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SWAP_IDLE: if (swap_req && frame_start) state_nxt = SWAP_ACK;
            SWAP_ACK:  if (!swap_req)               state_nxt = SWAP_IDLE;
            default:                                state_nxt = SWAP_IDLE;
        endcase
    end

    always_comb begin
        ack_nxt  = (state_nxt == SWAP_ACK);
        bank_nxt = rd_bank ^ ((state == SWAP_IDLE) && (state_nxt == SWAP_ACK));
    end

endmodule

// File: rtl/ssd1306_scan_sched.sv
// Raster-side read scheduler: maps parent raster position into the scaled OLED window,
// issues one framebuffer byte read per active pixel and produces per-pixel on/window flags.
module ssd1306_scan_sched
    import ssd1306_pkg::*;
#(
    parameter int unsigned X_OLED_SIZE = OLED_COLS,
    parameter int unsigned Y_OLED_SIZE = OLED_ROWS,
    parameter int unsigned SCALE_LOG2  = 3,
    parameter int unsigned X_OFFSET    = 128,
    parameter int unsigned Y_OFFSET    = 144
) (
    input  logic                 raster_clk,
    input  logic                 rst,
    input  logic                 raster_de,
    input  logic                 raster_h_synk,
    input  logic                 raster_v_synk,
    input  logic                 invert,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 rd_en,
    output logic [FB_ADDR_W-1:0] rd_addr,
    input  logic [7:0]           rd_data,
    output logic                 pix_de,
    output logic                 pix_win,
    output logic                 pix_on,
    output logic                 frame_start
);

    localparam int unsigned X_END = X_OFFSET + (X_OLED_SIZE << SCALE_LOG2);
    localparam int unsigned Y_END = Y_OFFSET + (Y_OLED_SIZE << SCALE_LOG2);
    localparam logic [POS_W-1:0] POS_MAX = '1;

    logic [POS_W-1:0]    px;
    logic [POS_W-1:0]    py;
    logic                de_q;
    logic                vs_q;
    logic                rd_bank;
    logic                win;
    logic [POS_W-1:0]    x_rel;
    logic [POS_W-1:0]    y_rel;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    fb_addr_t            addr;
    pix_stage_t          s1;

    // Raster position counters; sync clears take priority over counting.
    always_ff @(posedge raster_clk or posedge rst) begin
        if (rst) begin
            px   <= '0;
            py   <= '0;
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            de_q <= raster_de;
            vs_q <= raster_v_synk;
            if (raster_h_synk) begin
                px <= '0;
            end else if (raster_de && (px != POS_MAX)) begin
                px <= px + POS_W'(1);
            end
            if (raster_v_synk) begin
                py <= '0;
            end else if (de_q && !raster_de && (py != POS_MAX)) begin
                py <= py + POS_W'(1);
            end
        end
    end

    // Window test is done on the full-width position before slicing col/row.
    always_comb begin
        win   = (32'(px) >= X_OFFSET) && (32'(px) < X_END) &&
                (32'(py) >= Y_OFFSET) && (32'(py) < Y_END);
        x_rel = px - POS_W'(X_OFFSET);
        y_rel = py - POS_W'(Y_OFFSET);
        col   = COL_BITS'(x_rel >> SCALE_LOG2);
        row   = ROW_BITS'(y_rel >> SCALE_LOG2);
    end

    always_comb begin
        rd_en     = raster_de & win;
        addr.bank = rd_bank;
        addr.page = row[ROW_BITS-1 -: PAGE_BITS];
        addr.col  = col;
        rd_addr   = rd_en ? FB_ADDR_W'(addr) : '0;
    end

    // Two-stage pixel pipeline: stage 1 waits for rd_data, stage 2 drives the colour mux.
    always_ff @(posedge raster_clk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            pix_de      <= 1'b0;
            pix_win     <= 1'b0;
            pix_on      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            s1.de       <= raster_de;
            s1.win      <= win;
            s1.bit_sel  <= row[BIT_BITS-1:0];
            pix_de      <= s1.de;
            pix_win     <= s1.de & s1.win;
            pix_on      <= s1.de & s1.win & (rd_data[s1.bit_sel] ^ invert);
            frame_start <= raster_v_synk & ~vs_q;
        end
    end

    ssd1306_bank_swap u_bank_swap (
        .raster_clk  (raster_clk),
        .rst         (rst),
        .frame_start (frame_start),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .rd_bank     (rd_bank)
    );

endmodule
